// File: rtl/leitor_matriculas.sv
// Plate assembler: builds N_CHARS-char plates from a strobed char stream.
// Optional LEITOR_DUP_FILTER_EN suppresses a plate equal to the last emitted.
module leitor_matriculas #(
  parameter int N_CHARS = 6,
  parameter int CHAR_W  = 4,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 10
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [CHAR_W-1:0]           CharIn,
  input  logic                        CharVal,
  input  logic                        CharSof,
  output logic [N_CHARS*CHAR_W-1:0]   Matricula,
  output logic                        MatrVal,
  output logic                        Erro,
  output logic [1:0]                  ErroCod,
  output logic                        Ocupado
);

  localparam int PW = N_CHARS * CHAR_W;
  localparam int SW = PW - CHAR_W;
  localparam int IW = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(N_CHARS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECEBE,
    DESCARTA
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SW-1:0]     sr_q;
  logic              char_ok;
  logic [PW-1:0]     plate_d;
  logic              dup;

  assign char_ok = (CharIn != {CHAR_W{1'b1}});
  assign plate_d = {sr_q, CharIn};

`ifdef LEITOR_DUP_FILTER_EN
  logic [PW-1:0] last_q;
  assign dup = (plate_d == last_q);
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      sr_q      <= '0;
      Matricula <= '0;
      MatrVal   <= 1'b0;
      Erro      <= 1'b0;
      ErroCod   <= 2'b00;
      Ocupado   <= 1'b0;
`ifdef LEITOR_DUP_FILTER_EN
      last_q    <= '0;
`endif
    end else begin
      MatrVal <= 1'b0;
      Erro    <= 1'b0;
      unique case (state_q)
        IDLE, DESCARTA: begin
          if (CharVal && CharSof && char_ok) begin
            sr_q    <= SW'(CharIn);
            idx_q   <= IW'(1);
            cnt_q   <= '0;
            state_q <= RECEBE;
            Ocupado <= 1'b1;
          end else if (CharVal && CharSof && state_q == IDLE) begin
            Erro    <= 1'b1;
            ErroCod <= 2'b01;
            state_q <= DESCARTA;
          end
        end
        RECEBE: begin
          if (!CharVal) begin
            if (cnt_q == CNT_MAX) begin
              Erro    <= 1'b1;
              ErroCod <= 2'b10;
              idx_q   <= '0;
              cnt_q   <= '0;
              state_q <= IDLE;
              Ocupado <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (!char_ok) begin
            Erro    <= 1'b1;
            ErroCod <= 2'b01;
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= DESCARTA;
            Ocupado <= 1'b0;
          end else if (CharSof) begin
            // Resync: the partial plate is dropped, this char restarts it
            Erro    <= 1'b1;
            ErroCod <= 2'b11;
            sr_q    <= SW'(CharIn);
            idx_q   <= IW'(1);
            cnt_q   <= '0;
          end else if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            Ocupado <= 1'b0;
            if (!dup) begin
              Matricula <= plate_d;
              MatrVal   <= 1'b1;
`ifdef LEITOR_DUP_FILTER_EN
              last_q    <= plate_d;
`endif
            end
          end else begin
            sr_q  <= plate_d[SW-1:0];
            idx_q <= idx_q + IW'(1);
            cnt_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          Ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_matriculas.sv
// Scoreboard bench for leitor_matriculas: directed plates, errors,
// timeout boundary, back-to-back frames and mid-frame reset.
module tb_leitor_matriculas;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  CharIn;
  logic        CharVal;
  logic        CharSof;
  logic [23:0] Matricula;
  logic        MatrVal;
  logic        Erro;
  logic [1:0]  ErroCod;
  logic        Ocupado;

  leitor_matriculas dut (
    .CLK       (CLK),
    .RST       (RST),
    .CharIn    (CharIn),
    .CharVal   (CharVal),
    .CharSof   (CharSof),
    .Matricula (Matricula),
    .MatrVal   (MatrVal),
    .Erro      (Erro),
    .ErroCod   (ErroCod),
    .Ocupado   (Ocupado)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [23:0] data;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] c, input logic sof);
    CharIn  = c;
    CharVal = 1'b1;
    CharSof = sof;
    @(posedge CLK);
    #1;
    CharVal = 1'b0;
    CharSof = 1'b0;
  endtask

  task automatic idle(input int n);
    CharVal = 1'b0;
    CharSof = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_plate(input logic [23:0] p);
    logic [23:0] v;
    v = p;
    for (int i = 5; i >= 0; i--)
      send(v[i*4 +: 4], i == 5);
  endtask

  task automatic exp_plate(input logic [23:0] p);
    exp_t e;
    e.err  = 1'b0;
    e.data = p;
    e.code = 2'b00;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic exp_err(input logic [1:0] c, input int at);
    exp_t e;
    e.err  = 1'b1;
    e.data = '0;
    e.code = c;
    e.cyc  = at;
    q.push_back(e);
  endtask

  // Monitor: every output pulse must match the head of the queue
  always @(negedge CLK) begin
    exp_t e;
    if (MatrVal === 1'b1 && Erro === 1'b1)
      chk("pulse_overlap", 32'd1, 32'd0);
    if (MatrVal === 1'b1 || Erro === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, MatrVal, Erro}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {31'd0, Erro}, {31'd0, e.err});
        chk("pulse_cycle", cyc, e.cyc);
        if (e.err)
          chk("errocod", {30'd0, ErroCod}, {30'd0, e.code});
        else
          chk("matricula", {8'd0, Matricula}, {8'd0, e.data});
      end
    end
  end

  initial begin
    RST     = 1'b1;
    CharIn  = 4'h0;
    CharVal = 1'b0;
    CharSof = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_matricula", {8'd0, Matricula}, 32'd0);
    chk("rst_outs", {27'd0, MatrVal, Erro, ErroCod, Ocupado}, 32'd0);
    RST = 1'b0;
    idle(2);

    // 1: plain plate
    send(4'h1, 1'b1);
    chk("t1_ocupado", {31'd0, Ocupado}, 32'd1);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    exp_plate(24'h123456);
    idle(3);
    chk("t1_hold", {8'd0, Matricula}, 32'h123456);
    chk("t1_idle", {31'd0, Ocupado}, 32'd0);

    // 2: bad char, trailing chars discarded, then recovery
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    send(4'hF, 1'b0);
    exp_err(2'b01, cyc);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    chk("t2_discard", {31'd0, Ocupado}, 32'd0);
    send_plate(24'hABCDE0);
    exp_plate(24'hABCDE0);
    idle(3);

    // 3a: timeout exactly TIMEOUT cycles after the last char
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    exp_err(2'b10, cyc + 1000);
    idle(1000);
    chk("t3_to_idle", {31'd0, Ocupado}, 32'd0);
    chk("t3_code_hold", {30'd0, ErroCod}, 32'd2);
    idle(3);

    // 3b: char on the expiry edge wins over the timeout
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    idle(999);
    chk("t3b_busy", {31'd0, Ocupado}, 32'd1);
    send(4'h4, 1'b0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    exp_plate(24'h123456);
    idle(3);

    // 4: SOF mid-frame restarts the plate
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h7, 1'b1);
    exp_err(2'b11, cyc);
    send(4'h8, 1'b0);
    send(4'h9, 1'b0);
    send(4'h7, 1'b0);
    send(4'h8, 1'b0);
    send(4'h9, 1'b0);
    exp_plate(24'h789789);
    idle(3);

    // 5: same plate back-to-back, no dead cycle
    send_plate(24'h123456);
    exp_plate(24'h123456);
    send_plate(24'h123456);
`ifndef LEITOR_DUP_FILTER_EN
    exp_plate(24'h123456);
`endif
    idle(3);
    chk("t5_hold", {8'd0, Matricula}, 32'h123456);

    // 6: reset mid-frame
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("t6_matricula", {8'd0, Matricula}, 32'd0);
    chk("t6_outs", {27'd0, MatrVal, Erro, ErroCod, Ocupado}, 32'd0);
    RST = 1'b0;
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    idle(3);
    chk("t6_after", {8'd0, Matricula}, 32'd0);
    chk("t6_idle", {31'd0, Ocupado}, 32'd0);

    idle(5);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
